// File: rtl/exec_stage_if.sv
// Instruction handshake and register-file port bundle for exec_stage.
// master = instruction source / register file side, slave = exec_stage.
interface exec_stage_if #(
    parameter int WIDTH = 16,
    parameter int AW    = 4
);
    logic             in_valid;
    logic             in_ready;
    logic [3:0]       op;
    logic [AW-1:0]    src;
    logic [AW-1:0]    dst;
    logic [AW-1:0]    ra1;
    logic [AW-1:0]    ra2;
    logic [WIDTH-1:0] rd1;
    logic [WIDTH-1:0] rd2;
    logic [WIDTH-1:0] wd;
    logic             regwrite;
    logic [2:0]       flags;

    modport master (
        output in_valid, op, src, dst, rd1, rd2,
        input  in_ready, ra1, ra2, wd, regwrite, flags
    );

    modport slave (
        input  in_valid, op, src, dst, rd1, rd2,
        output in_ready, ra1, ra2, wd, regwrite, flags
    );
endinterface

// File: rtl/exec_stage.sv
// Multi-cycle execute stage: register read, single-cycle ALU or 16-step
// shift-add multiply, then one-cycle write-back with {C,N,Z} flags.
module exec_stage #(
    parameter int WIDTH = 16,
    parameter int AW    = 4
) (
    input  logic        clk,
    input  logic        reset,
    exec_stage_if.slave bus
);
    localparam int            CW       = $clog2(WIDTH);
    localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

    typedef enum logic [2:0] {S_IDLE, S_READ, S_EXEC, S_MUL, S_WB} state_t;

    state_t           state_q;
    logic [3:0]       op_q;
    logic [AW-1:0]    ra1_q, ra2_q;
    logic [WIDTH-1:0] a_q, b_q, prod_q, wd_q;
    logic             regwrite_q;
    logic [2:0]       flags_q;
    logic [CW-1:0]    cnt_q;

    logic [WIDTH-1:0] res_d, prod_d;
    logic             c_d, wr_d, upd_d;
    logic [WIDTH:0]   add_w, shl_w, shr_w;
    logic [3:0]       sh;

    // Shifts are widened by one bit so the last bit shifted out lands in
    // the extra position; a zero shift therefore yields carry 0.
    always_comb begin
        sh     = a_q[3:0];
        add_w  = {1'b0, b_q} + {1'b0, a_q};
        shl_w  = {1'b0, b_q} << sh;
        shr_w  = {b_q, 1'b0} >> sh;
        res_d  = '0;
        c_d    = 1'b0;
        wr_d   = 1'b1;
        upd_d  = 1'b1;
        prod_d = a_q[0] ? (prod_q + b_q) : prod_q;
        case (op_q)
            4'd0: begin res_d = add_w[WIDTH-1:0]; c_d = add_w[WIDTH]; end
            4'd1: begin res_d = b_q - a_q; c_d = (b_q < a_q); end
            4'd2: res_d = b_q & a_q;
            4'd3: res_d = b_q | a_q;
            4'd4: res_d = b_q ^ a_q;
            4'd5: res_d = a_q;
            4'd6: begin res_d = shl_w[WIDTH-1:0]; c_d = shl_w[WIDTH]; end
            4'd7: begin res_d = shr_w[WIDTH:1]; c_d = shr_w[0]; end
            4'd8: begin res_d = b_q - a_q; c_d = (b_q < a_q); wr_d = 1'b0; end
            default: begin wr_d = 1'b0; upd_d = 1'b0; end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= S_IDLE;
            op_q       <= '0;
            ra1_q      <= '0;
            ra2_q      <= '0;
            a_q        <= '0;
            b_q        <= '0;
            prod_q     <= '0;
            wd_q       <= '0;
            regwrite_q <= 1'b0;
            flags_q    <= '0;
            cnt_q      <= '0;
        end else begin
            regwrite_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (bus.in_valid) begin
                        op_q    <= bus.op;
                        ra1_q   <= bus.src;
                        ra2_q   <= bus.dst;
                        state_q <= S_READ;
                    end
                end
                S_READ: begin
                    a_q     <= bus.rd1;
                    b_q     <= bus.rd2;
                    prod_q  <= '0;
                    cnt_q   <= '0;
                    state_q <= (op_q == 4'd9) ? S_MUL : S_EXEC;
                end
                S_EXEC: begin
                    if (wr_d) begin
                        wd_q       <= res_d;
                        regwrite_q <= 1'b1;
                    end
                    if (upd_d)
                        flags_q <= {c_d, res_d[WIDTH-1], (res_d == '0)};
                    state_q <= S_WB;
                end
                S_MUL: begin
                    prod_q <= prod_d;
                    a_q    <= a_q >> 1;
                    b_q    <= b_q << 1;
                    cnt_q  <= cnt_q + 1'b1;
                    if (cnt_q == CNT_LAST) begin
                        wd_q       <= prod_d;
                        regwrite_q <= 1'b1;
                        flags_q    <= {1'b0, prod_d[WIDTH-1], (prod_d == '0)};
                        state_q    <= S_WB;
                    end
                end
                S_WB: begin
                    ra1_q   <= '0;
                    ra2_q   <= '0;
                    state_q <= S_IDLE;
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign bus.in_ready = (state_q == S_IDLE) && !reset;
    assign bus.ra1      = ra1_q;
    assign bus.ra2      = ra2_q;
    assign bus.wd       = wd_q;
    assign bus.regwrite = regwrite_q;
    assign bus.flags    = flags_q;
endmodule

// File: tb/tb_exec_stage.sv
// Directed bench for exec_stage: register-file model, write-back scoreboard
// keyed on expected cycle, and a small arithmetic reference.
module tb_exec_stage;
    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    exec_stage_if #(.WIDTH(16), .AW(4)) bus ();
    exec_stage #(.WIDTH(16), .AW(4)) dut (.clk(clk), .reset(reset), .bus(bus));

    logic [15:0] regs [16];
    logic        pl_en;
    logic [3:0]  pl_addr;
    logic [15:0] pl_data;

    assign bus.rd1 = regs[bus.ra1];
    assign bus.rd2 = regs[bus.ra2];

    always @(posedge clk) begin
        if (pl_en)             regs[pl_addr] <= pl_data;
        else if (bus.regwrite) regs[bus.ra2] <= bus.wd;
    end

    int unsigned cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [3:0]  addr;
        logic [15:0] data;
        logic [2:0]  flags;
        int unsigned cyc;
    } exp_t;

    exp_t        sb[$];
    int unsigned total = 0;
    int unsigned passed = 0;
    int unsigned fails = 0;
    logic [2:0]  exp_flags;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else begin
            fails++;
            $error("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Every wait goes through here so write-backs are scored on each cycle.
    task automatic tick();
        exp_t e;
        @(negedge clk);
        if (bus.regwrite !== 1'b0) begin
            if (sb.size() == 0) begin
                check("spurious_regwrite", 32'(bus.regwrite), 32'd0);
            end else begin
                e = sb.pop_front();
                check("wb_cycle", 32'(cyc), 32'(e.cyc));
                check("wb_addr", 32'(bus.ra2), 32'(e.addr));
                check("wb_data", 32'(bus.wd), 32'(e.data));
                check("wb_flags", 32'(bus.flags), 32'(e.flags));
            end
        end
    endtask

    task automatic wait_ready(input int unsigned budget);
        int unsigned n = 0;
        while (bus.in_ready !== 1'b1 && n < budget) begin
            tick();
            n++;
        end
        if (bus.in_ready !== 1'b1) check("ready_timeout", 32'(bus.in_ready), 32'd1);
    endtask

    task automatic preload(input logic [3:0] a, input logic [15:0] d);
        pl_en = 1'b1; pl_addr = a; pl_data = d;
        tick();
        pl_en = 1'b0;
    endtask

    function automatic void ref_alu(input logic [3:0] o, input logic [15:0] a, input logic [15:0] b,
                                    output logic wr, output logic upd,
                                    output logic [15:0] res, output logic [2:0] fl);
        logic        c;
        int          sh;
        logic [31:0] p;
        sh = int'(a[3:0]);
        c = 1'b0; wr = 1'b1; upd = 1'b1; res = 16'h0; p = 32'h0;
        case (o)
            4'd0: begin res = b + a; c = (32'(b) + 32'(a)) > 32'h0000FFFF; end
            4'd1: begin res = b - a; c = (b < a); end
            4'd2: res = b & a;
            4'd3: res = b | a;
            4'd4: res = b ^ a;
            4'd5: res = a;
            4'd6: begin res = b << sh; c = (sh != 0) ? b[16 - sh] : 1'b0; end
            4'd7: begin res = b >> sh; c = (sh != 0) ? b[sh - 1] : 1'b0; end
            4'd8: begin res = b - a; c = (b < a); wr = 1'b0; end
            4'd9: begin p = 32'(b) * 32'(a); res = p[15:0]; end
            default: begin wr = 1'b0; upd = 1'b0; end
        endcase
        fl = {c, res[15], (res == 16'h0)};
    endfunction

    task automatic run_op(input logic [3:0] o, input logic [3:0] s, input logic [3:0] d);
        logic        wr, upd;
        logic [15:0] res;
        logic [2:0]  fl;
        int unsigned lat, t;
        wait_ready(40);
        ref_alu(o, regs[s], regs[d], wr, upd, res, fl);
        lat = (o == 4'd9) ? 18 : 3;
        t = cyc;
        bus.in_valid = 1'b1; bus.op = o; bus.src = s; bus.dst = d;
        if (wr)  sb.push_back(exp_t'{d, res, fl, t + lat});
        if (upd) exp_flags = fl;
        tick();
        bus.in_valid = 1'b0;
        check($sformatf("busy_op%0d_c1", o), 32'(bus.in_ready), 32'd0);
        for (int unsigned k = 2; k <= lat; k++) begin
            tick();
            check($sformatf("busy_op%0d_c%0d", o, k), 32'(bus.in_ready), 32'd0);
        end
        tick();
        check($sformatf("ready_op%0d", o), 32'(bus.in_ready), 32'd1);
        check($sformatf("flags_op%0d", o), 32'(bus.flags), 32'(exp_flags));
        check($sformatf("sb_empty_op%0d", o), 32'(sb.size()), 32'd0);
    endtask

    task automatic run_vec(input logic [3:0] o, input logic [15:0] a, input logic [15:0] b,
                           input logic [3:0] s, input logic [3:0] d);
        preload(s, a);
        preload(d, b);
        run_op(o, s, d);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int unsigned t;
        reset = 1'b1;
        bus.in_valid = 1'b0; bus.op = '0; bus.src = '0; bus.dst = '0;
        pl_en = 1'b0; pl_addr = '0; pl_data = '0;
        exp_flags = 3'b000;
        tick();
        tick();
        check("rst_in_ready_low", 32'(bus.in_ready), 32'd0);
        @(posedge clk);
        #1 reset = 1'b0;
        tick();
        check("rst_in_ready", 32'(bus.in_ready), 32'd1);
        check("rst_regwrite", 32'(bus.regwrite), 32'd0);
        check("rst_wd", 32'(bus.wd), 32'd0);
        check("rst_flags", 32'(bus.flags), 32'd0);
        check("rst_ra1", 32'(bus.ra1), 32'd0);
        check("rst_ra2", 32'(bus.ra2), 32'd0);

        // Directed cases with hand-derived results
        preload(4'd1, 16'h0004); preload(4'd2, 16'h0003);
        run_op(4'd0, 4'd1, 4'd2);
        check("add_r2", 32'(regs[2]), 32'h0007);
        check("add_flags", 32'(bus.flags), 32'b000);

        preload(4'd2, 16'h0003);
        run_op(4'd1, 4'd1, 4'd2);
        check("sub_r2", 32'(regs[2]), 32'hFFFF);
        check("sub_flags", 32'(bus.flags), 32'b110);

        preload(4'd3, 16'h0100); preload(4'd4, 16'h0100);
        run_op(4'd9, 4'd3, 4'd4);
        check("mul_r4", 32'(regs[4]), 32'h0000);
        check("mul_flags", 32'(bus.flags), 32'b001);

        preload(4'd1, 16'h0005); preload(4'd2, 16'h0005);
        run_op(4'd8, 4'd1, 4'd2);
        check("cmp_flags", 32'(bus.flags), 32'b001);
        check("cmp_r2_kept", 32'(regs[2]), 32'h0005);

        // Remaining ops and boundaries against the reference
        run_vec(4'd2, 16'hF0F3, 16'h3C5A, 4'd7, 4'd8);
        run_vec(4'd3, 16'hF0F3, 16'h3C5A, 4'd7, 4'd8);
        run_vec(4'd4, 16'hF0F3, 16'hF0F3, 4'd7, 4'd8);
        run_vec(4'd5, 16'h8234, 16'h0000, 4'd7, 4'd0);
        check("mov_r0", 32'(regs[0]), 32'h8234);
        run_vec(4'd6, 16'h0004, 16'h9001, 4'd7, 4'd8);
        run_vec(4'd6, 16'h0000, 16'h8001, 4'd7, 4'd8);
        run_vec(4'd6, 16'h0013, 16'h2001, 4'd7, 4'd8);
        run_vec(4'd7, 16'h0001, 16'h8003, 4'd7, 4'd8);
        run_vec(4'd7, 16'h000F, 16'h8000, 4'd7, 4'd8);
        run_vec(4'd0, 16'h0001, 16'hFFFF, 4'd7, 4'd8);
        run_vec(4'd9, 16'h0011, 16'h1234, 4'd7, 4'd8);
        run_vec(4'd9, 16'hFFFF, 16'hFFFF, 4'd7, 4'd8);
        run_vec(4'd12, 16'h0001, 16'h0002, 4'd7, 4'd8);
        check("nop_r8_kept", 32'(regs[8]), 32'h0002);

        // in_valid held high: second instruction accepted four cycles later
        preload(4'd1, 16'h0004); preload(4'd2, 16'h0003);
        wait_ready(40);
        t = cyc;
        bus.in_valid = 1'b1; bus.op = 4'd0; bus.src = 4'd1; bus.dst = 4'd2;
        sb.push_back(exp_t'{4'd2, 16'h0007, 3'b000, t + 3});
        for (int unsigned k = 1; k <= 3; k++) begin
            tick();
            check($sformatf("b2b_busy_c%0d", k), 32'(bus.in_ready), 32'd0);
        end
        tick();
        check("b2b_ready_t4", 32'(bus.in_ready), 32'd1);
        sb.push_back(exp_t'{4'd2, 16'h000B, 3'b000, t + 7});
        exp_flags = 3'b000;
        for (int unsigned k = 5; k <= 7; k++) begin
            tick();
            if (k == 5) bus.in_valid = 1'b0;
            check($sformatf("b2b_busy_c%0d", k), 32'(bus.in_ready), 32'd0);
        end
        tick();
        check("b2b_ready_t8", 32'(bus.in_ready), 32'd1);
        check("b2b_sb_empty", 32'(sb.size()), 32'd0);
        check("b2b_r2", 32'(regs[2]), 32'h000B);

        // Reset in the middle of a multiply aborts it
        run_op(4'd8, 4'd1, 4'd1);
        preload(4'd3, 16'h0100); preload(4'd4, 16'h0100);
        wait_ready(40);
        t = cyc;
        bus.in_valid = 1'b1; bus.op = 4'd9; bus.src = 4'd3; bus.dst = 4'd4;
        tick();
        bus.in_valid = 1'b0;
        for (int unsigned k = 2; k <= 10; k++) tick();
        check("abort_at_t10", 32'(cyc - t), 32'd10);
        reset = 1'b1;
        #1 check("abort_rst_ready", 32'(bus.in_ready), 32'd0);
        @(posedge clk);
        #1 reset = 1'b0;
        tick();
        exp_flags = 3'b000;
        check("abort_ready_t11", 32'(bus.in_ready), 32'd1);
        check("abort_regwrite", 32'(bus.regwrite), 32'd0);
        check("abort_flags", 32'(bus.flags), 32'd0);
        check("abort_wd", 32'(bus.wd), 32'd0);
        for (int unsigned k = 0; k < 25; k++) tick();
        check("abort_r4_kept", 32'(regs[4]), 32'h0100);
        check("abort_sb_empty", 32'(sb.size()), 32'd0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule

// File: doc/exec_stage.md
EXEC_STAGE -- requirements
Module: exec_stage

Interface
REQ-001 Parameter: WIDTH, 16, datapath width in bits; all values below assume 16.
REQ-002 Parameter: AW, 4, register address width.
REQ-003 clk  input  1  single clock; all state changes on posedge clk.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 in_valid  input  1  instruction offered.
REQ-006 in_ready  output  1  block can accept an instruction.
REQ-007 op  input  4  opcode.
REQ-008 src  input  AW  source register (A operand).
REQ-009 dst  input  AW  destination register (B operand and write target).
REQ-010 ra1  output  AW  register-file read address 1.
REQ-011 ra2  output  AW  register-file read address 2 and write address.
REQ-012 rd1  input  WIDTH  register-file read data 1, combinational from ra1.
REQ-013 rd2  input  WIDTH  register-file read data 2, combinational from ra2.
REQ-014 wd  output  WIDTH  write-back data.
REQ-015 regwrite  output  1  write strobe to register file.
REQ-016 flags  output  3  {C,N,Z}, registered.

Function
REQ-017 States: IDLE, READ, EXEC, MUL, WB; in_ready SHALL be 1 only in IDLE.
REQ-018 IDLE: on in_valid&in_ready, capture op/src/dst and go to READ; otherwise stay.
REQ-019 ra1=captured src, ra2=captured dst from READ through WB; ra1=ra2=0 in IDLE.
REQ-020 READ: latch A<=rd1, B<=rd2; go to MUL if op=9, else EXEC.
REQ-021 EXEC: compute result in one cycle; go to WB.
REQ-022 Ops (result): 0 ADD B+A; 1 SUB B-A; 2 AND; 3 OR; 4 XOR; 5 MOV A; 6 SHL B<<A[3:0]; 7 SHR logical B>>A[3:0]; 8 CMP B-A flags only; 9 MUL low 16 bits of B*A; 10-15 NOP.
REQ-023 All arithmetic modulo 2^16; operands unsigned.
REQ-024 MUL: shift-add, one bit of A per cycle, exactly 16 cycles in MUL, then WB.
REQ-025 WB: regwrite=1 and wd=result for exactly one cycle for ops 0-7 and 9; regwrite=0 for CMP and NOP; then IDLE.
REQ-026 Writes to register 0 SHALL still assert regwrite; no special-casing.
REQ-027 Latency from accept cycle T: regwrite at T+3 (non-MUL), T+18 (MUL); in_ready again at T+4 / T+19.
REQ-028 Flags loaded on entry to WB for ops 0-9; NOP leaves flags unchanged.
REQ-029 Z=(result==0); N=result[15]; C=carry-out for ADD, borrow (B<A) for SUB/CMP, last bit shifted out for SHL/SHR (0 if shift amount 0), 0 for logical/MOV/MUL.
REQ-030 For CMP, "result" for Z/N is B-A, never written.
REQ-031 wd SHALL hold its last value outside WB; regwrite=0 outside WB.
REQ-032 in_valid outside IDLE is ignored; no instruction is queued.

Reset
REQ-033 While reset=1 at a posedge: state<=IDLE, regwrite=0, wd=0, flags=0, A=B=0, MUL counter=0.
REQ-034 in_ready=0 during the reset cycle, 1 in the first cycle after reset deasserts.
REQ-035 Reset in any state aborts the operation: no regwrite, flags not updated.

Verification
REQ-036 r1=0x0004, r2=0x0003; ADD src=1 dst=2 -> T+3: regwrite=1, ra2=2, wd=0x0007; flags C=0,N=0,Z=0.
REQ-037 Same preload; SUB src=1 dst=2 -> wd=0xFFFF, flags C=1,N=1,Z=0.
REQ-038 r3=r4=0x0100; MUL src=3 dst=4 -> regwrite only at T+18, wd=0x0000, Z=1; in_ready=0 T+1..T+18.
REQ-039 r1=r2=0x0005; CMP src=1 dst=2 -> regwrite never 1, Z=1, C=0.
REQ-040 MUL accepted at T, reset at T+10 -> no regwrite ever, flags=0, in_ready=1 at T+11.
REQ-041 in_valid held high with two ADDs -> second accepted at T+4, regwrite at T+3 and T+7 only.
